// File: rtl/dist_min_scanner.sv
// Extract-min scanner for the Dijkstra engine: streams the distance RAM
// and keeps the unvisited node with the smallest finite distance.
module dist_min_scanner #(
  parameter int                 ADDR_W = 5,
  parameter int                 DATA_W = 8,
  parameter int                 RD_LAT = 2,
  parameter logic [DATA_W-1:0]  INF    = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_nodes,
  input  logic [2**ADDR_W-1:0]  visited,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_W-1:0]     ram_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_W-1:0]     min_node,
  output logic [DATA_W-1:0]     min_dist
);

  localparam int LAST = RD_LAT - 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W:0]        n_q, n_d;
  logic [2**ADDR_W-1:0]   vis_q, vis_d;
  logic [RD_LAT-1:0]      pv_q, pv_d;
  logic [ADDR_W-1:0]      pi_q [RD_LAT];
  logic [ADDR_W-1:0]      pi_d [RD_LAT];
  logic                   found_q, found_d;
  logic [ADDR_W-1:0]      node_q, node_d;
  logic [DATA_W-1:0]      dist_q, dist_d;
  logic                   issue;
  logic                   take;

  // Tail of the pipe lines up with the registered RAM data.
  assign take = pv_q[LAST]
             && !vis_q[pi_q[LAST]]
             && (ram_rd_data != INF)
             && (!found_q || (ram_rd_data < dist_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    vis_d   = vis_q;
    found_d = found_q;
    node_d  = node_q;
    dist_d  = dist_q;
    issue   = 1'b0;

    if (take) begin
      found_d = 1'b1;
      node_d  = pi_q[LAST];
      dist_d  = ram_rd_data;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_nodes;
          vis_d   = visited;
          cnt_d   = '0;
          found_d = 1'b0;
          node_d  = '0;
          dist_d  = '0;
          state_d = (num_nodes == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if ({1'b0, cnt_q} == n_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        if (pv_q == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pv_d[0] = issue;
    pi_d[0] = cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      vis_q   <= '0;
      pv_q    <= '0;
      found_q <= 1'b0;
      node_q  <= '0;
      dist_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) pi_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      vis_q   <= vis_d;
      pv_q    <= pv_d;
      found_q <= found_d;
      node_q  <= node_d;
      dist_q  <= dist_d;
      for (int i = 0; i < RD_LAT; i++) pi_q[i] <= pi_d[i];
    end
  end

  assign ram_rd_addr = (state_q == ISSUE) ? cnt_q : '0;
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign min_node    = node_q;
  assign min_dist    = dist_q;

endmodule

// File: tb/tb_dist_min_scanner.sv
// Scoreboard bench for dist_min_scanner with a 2-cycle RAM model.
module tb_dist_min_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  num_nodes;
  logic [31:0] visited;
  logic [4:0]  ram_rd_addr;
  logic [7:0]  ram_rd_data;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  min_node;
  logic [7:0]  min_dist;

  dist_min_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_nodes   (num_nodes),
    .visited     (visited),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .min_node    (min_node),
    .min_dist    (min_dist)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  logic [4:0] a_q;
  logic [7:0] d_q;
  always @(posedge clk) begin
    a_q <= ram_rd_addr;
    d_q <= mem[a_q];
  end
  assign ram_rd_data = d_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       f;
    logic [4:0] n;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", busy, 0);
        chk("found", found, e.f);
        if (e.f) begin
          chk("min_node", min_node, e.n);
          chk("min_dist", min_dist, e.d);
        end
      end
    end
  end

  task automatic scan(input int n, input logic [31:0] vis,
                      input logic ef, input logic [4:0] en,
                      input logic [7:0] ed, input bit disturb);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    num_nodes = n[5:0];
    visited   = vis;
    @(posedge clk);
    #1;
    chk("busy_after_start", busy, 1);
    e.f   = ef;
    e.n   = en;
    e.d   = ed;
    e.cyc = cyc + ((n == 0) ? 1 : n + 3);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) chk("addr_zero_n0", ram_rd_addr, 0);
    if (disturb) begin
      repeat (3) @(negedge clk);
      start     = 1'b1;
      visited   = ~vis;
      num_nodes = 6'd3;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_nodes = '0;
    visited   = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(100 - i);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_addr", ram_rd_addr, 0);
    chk("rst_dist", min_dist, 0);
    rst_n = 1'b1;

    // descending distances: last node wins
    scan(32, 32'h0, 1'b1, 5'd31, 8'd69, 1'b0);
    scan(5, 32'h0, 1'b1, 5'd4, 8'd96, 1'b0);
    scan(5, 32'h10, 1'b1, 5'd3, 8'd97, 1'b0);

    // tie resolves to lower index; nodes past N hold 0
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    mem[0] = 8'd50; mem[1] = 8'd20; mem[2] = 8'd20; mem[3] = 8'd90;
    scan(4, 32'h0, 1'b1, 5'd1, 8'd20, 1'b0);

    // only finite node is visited
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    mem[7] = 8'd5;
    scan(32, 32'h80, 1'b0, 5'd0, 8'd0, 1'b0);
    scan(32, 32'h0, 1'b1, 5'd7, 8'd5, 1'b0);

    scan(0, 32'h0, 1'b0, 5'd0, 8'd0, 1'b0);

    // reset mid-scan
    for (int i = 0; i < 32; i++) mem[i] = 8'(100 - i);
    @(negedge clk);
    start     = 1'b1;
    num_nodes = 6'd32;
    visited   = 32'h0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("found_midscan", found, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_found", found, 0);
    chk("abort_node", min_node, 0);
    chk("abort_dist", min_dist, 0);
    chk("abort_addr", ram_rd_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_abort", busy, 0);
    scan(32, 32'hC000_0000, 1'b1, 5'd29, 8'd71, 1'b0);

    // start pulse and visited change while busy are ignored
    scan(32, 32'h8000_0000, 1'b1, 5'd30, 8'd70, 1'b1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
